// File: rtl/uart_tx_buffered_if.sv
// Byte-write and serial-status bundle between the UART peripheral and its transmitter.
// Latency: none; this is wiring only.
// Backpressure: the writer watches tx_full, and a write made while full is dropped and flagged by tx_overflow.
interface uart_tx_buffered_if;
  logic       tx_send;
  logic [7:0] Tx_Data;
  logic       tx;
  logic [2:0] tx_state;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_overflow;

  // Peripheral side: issues writes and observes the transmitter.
  modport master (
    output tx_send, Tx_Data,
    input  tx, tx_state, tx_full, tx_empty, tx_busy, tx_overflow
  );

  // Transmitter side.
  modport slave (
    input  tx_send, Tx_Data,
    output tx, tx_state, tx_full, tx_empty, tx_busy, tx_overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queues bytes and sends 11-bit frames (start, 8 data bits LSB first, even parity, stop).
// Latency: a write to an idle, empty queue drops tx on the following edge. Each frame lasts 11*CLKS_PER_BIT cycles, and frames go out back to back.
// Backpressure: tx_full rejects writes, and a rejected write pulses tx_overflow for one cycle. Defining UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 5210,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  uart_tx_buffered_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  // Stop elaboration on depths that the wrap-bit pointer scheme cannot represent.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       push;
  logic       pop;

  // A pop in the same cycle does not free space, so a write is accepted only on the registered full flag.
  assign push = bus.tx_send && !full;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // The pointers carry an extra wrap bit and roll over naturally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset because the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.Tx_Data;
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign full  = hold_vld_q;
  assign empty = !hold_vld_q;
  assign head  = hold_q;

  // Single holding register. A push needs it empty and a pop needs it full, so the two never coincide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push) begin
      hold_q     <= bus.Tx_Data;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          overflow_q;
  logic          bit_done;

  assign bit_done = (timer_q == TMAX);

  // State register. Reset abandons any frame and returns the line high at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      overflow_q <= bus.tx_send && full;
    end
  end

  // Next-state logic. tx_d holds the line value for the state being entered, so tx comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (state_q != IDLE) timer_d = bit_done ? '0 : timer_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          parity_d = ^head;
          tx_d     = 1'b0;
          state_d  = START;
          timer_d  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = PARITY;
            bit_idx_d = 3'd0;
            tx_d      = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // If another byte is waiting, go straight to the next start bit with no idle gap.
        if (bit_done) begin
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = ^head;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.tx          = tx_q;
  assign bus.tx_state    = state_q;
  assign bus.tx_full     = full;
  assign bus.tx_empty    = empty;
  assign bus.tx_busy     = (state_q != IDLE) || !empty;
  assign bus.tx_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=10.
// It samples on the falling clock edge and decodes each frame at mid-bit.
// When built with UART_TX_FIFO_EN it also exercises the deep-FIFO burst case.
module tb_uart_tx_buffered;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic n_rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_send = 1'b1;
    bus.Tx_Data = b;
    @(negedge clk);
    bus.tx_send = 1'b0;
  endtask

  // Waits for a start bit, samples all 11 bits at mid-bit, then checks the frame length and the state that follows.
  task automatic rx_frame(input string tag, input logic [7:0] data, input logic par,
                          input logic [2:0] after_state);
    logic [10:0] got;
    logic [10:0] exp;
    int n;
    exp = {1'b1, par, data, 1'b0};
    got = '0;
    n = 0;
    while (bus.tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, bus.tx, 0);
    if (bus.tx !== 1'b0) return;
    check({tag, "_st_start"}, bus.tx_state, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      got[i] = bus.tx;
      if (i < 10) repeat (CPB) @(negedge clk);
    end
    check({tag, "_bits"}, got, exp);
    check({tag, "_rx_parity_err"}, got[9] ^ (^got[8:1]), 0);
    repeat (5) @(negedge clk);
    check({tag, "_st_stop_end"}, bus.tx_state, 4);
    @(negedge clk);
    check({tag, "_st_after"}, bus.tx_state, after_state);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    check({tag, "_tx_low_cycles"}, lows, 0);
    check({tag, "_busy"}, bus.tx_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst       = 1'b0;
    bus.tx_send = 1'b0;
    bus.Tx_Data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_state", bus.tx_state, 0);
    check("rst_empty", bus.tx_empty, 1);
    check("rst_full", bus.tx_full, 0);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_ovf", bus.tx_overflow, 0);
    n_rst = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_tx", bus.tx, 1);
    check("idle_state", bus.tx_state, 0);
    check("idle_busy", bus.tx_busy, 0);
    check("idle_empty", bus.tx_empty, 1);

    // 0xA5: the byte is enqueued at edge N, and tx falls and the state enters START at N+1.
    send(8'hA5);
    check("a5_pre_tx", bus.tx, 1);
    check("a5_pre_empty", bus.tx_empty, 0);
    check("a5_pre_busy", bus.tx_busy, 1);
    @(negedge clk);
    check("a5_fall_tx", bus.tx, 0);
    check("a5_fall_empty", bus.tx_empty, 1);
    rx_frame("a5", 8'hA5, 1'b0, 3'd0);
    check("a5_done_busy", bus.tx_busy, 0);

    send(8'h01);
    rx_frame("x01", 8'h01, 1'b1, 3'd0);
    send(8'h00);
    rx_frame("x00", 8'h00, 1'b0, 3'd0);

`ifdef UART_TX_FIFO_EN
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          if (i == 5) begin
            check("burst_full", bus.tx_full, 1);
            check("burst_ovf_pre", bus.tx_overflow, 0);
          end
          bus.tx_send = 1'b1;
          bus.Tx_Data = 8'h11 * (i + 1);
          @(negedge clk);
        end
        bus.tx_send = 1'b0;
        check("burst_ovf_pulse", bus.tx_overflow, 1);
        @(negedge clk);
        check("burst_ovf_clear", bus.tx_overflow, 0);
      end
      begin
        rx_frame("b11", 8'h11, 1'b0, 3'd1);
        rx_frame("b22", 8'h22, 1'b0, 3'd1);
        rx_frame("b33", 8'h33, 1'b0, 3'd1);
        rx_frame("b44", 8'h44, 1'b0, 3'd1);
        rx_frame("b55", 8'h55, 1'b0, 3'd0);
      end
    join
    quiet("burst_after", 200);
`else
    fork
      begin
        send(8'h11);
        repeat (2) @(negedge clk);
        send(8'h22);
        check("hold_full", bus.tx_full, 1);
        repeat (2) @(negedge clk);
        check("hold_ovf_pre", bus.tx_overflow, 0);
        send(8'h33);
        check("hold_ovf_pulse", bus.tx_overflow, 1);
        @(negedge clk);
        check("hold_ovf_clear", bus.tx_overflow, 0);
      end
      begin
        rx_frame("h11", 8'h11, 1'b0, 3'd1);
        rx_frame("h22", 8'h22, 1'b0, 3'd0);
      end
    join
    quiet("hold_after", 200);
`endif

    // Assert reset in the middle of the data bits while further bytes are queued.
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    repeat (16) @(negedge clk);
    check("mid_state_data", bus.tx_state, 2);
    check("mid_empty_pre", bus.tx_empty, 0);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_tx", bus.tx, 1);
    check("mid_rst_state", bus.tx_state, 0);
    check("mid_rst_empty", bus.tx_empty, 1);
    check("mid_rst_full", bus.tx_full, 0);
    @(negedge clk);
    n_rst = 1'b1;
    quiet("post_rst", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
